// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared types and helpers for the round-robin adder arbiter
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Fixed 16-bit form; callers pad and slice to their counter width (CNTW <= 16).
    function automatic logic [15:0] bin2gray(input logic [15:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one registered adder among NREQ requesters with round-robin grant
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id,
    output logic [CNTW-1:0]       issue_cnt_gray
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   gray_q, gray_d;

    logic              arb_en;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              accept;
    logic [WIDTH:0]    add_full;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept = |(req_valid & gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            rsp_id_q <= '0;
            cnt_q    <= '0;
            gray_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            rsp_id_q <= rsp_id_d;
            cnt_q    <= cnt_d;
            gray_q   <= gray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = accept ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are only offered when the operand registers are free to be overwritten.
    always_comb begin
        arb_en    = rst_n && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
        req_ready = gnt;
        rsp_valid = (state_q == RESP);
    end

    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, b_q};
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        rsp_id_d = rsp_id_q;
        cnt_d    = cnt_q;
        if (accept) begin
            a_d   = req_a[gnt_idx*WIDTH +: WIDTH];
            b_d   = req_b[gnt_idx*WIDTH +: WIDTH];
            id_d  = gnt_idx;
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            cnt_d = cnt_q + CNTW'(1);
        end
        // Result registers load only in EXEC, so a back-to-back grant in RESP leaves the response stable.
        if (state_q == EXEC) begin
            sum_d    = add_full[WIDTH-1:0];
            carry_d  = add_full[WIDTH];
            rsp_id_d = id_q;
        end
        gray_d = CNTW'(bin2gray(16'(cnt_d)));
    end

    assign rsp_sum        = sum_q;
    assign rsp_carry      = carry_q;
    assign rsp_id         = rsp_id_q;
    assign issue_cnt_gray = gray_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;
    logic [CNTW-1:0]       issue_cnt_gray;

    int nvec;
    int nerr;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    adder_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .CNTW  (CNTW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_sum        (rsp_sum),
        .rsp_carry      (rsp_carry),
        .rsp_id         (rsp_id),
        .issue_cnt_gray (issue_cnt_gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        nvec++;
        if ({req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, issue_cnt_gray} !== '0) begin
            nerr++;
            $display("FAIL %s: rdy=%b vld=%b sum=%h c=%b id=%0d gray=%b, all must be 0",
                     tag, req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, issue_cnt_gray);
        end
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = NREQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = 1'($urandom);
            @(negedge clk);
            check_all_zero("reset_outputs");
            next_cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        nvec++;
        if (dut.state_q !== IDLE) begin
            nerr++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        check_all_zero("after_release");
        next_cycle();
    endtask

    task automatic test_fairness;
        logic [NREQ-1:0]  exp_gnt [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                           4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        logic [WIDTH-1:0] exp_sum [4]  = '{8'h01, 8'h12, 8'h23, 8'h34};
        do_reset();
        req_a     = {8'h31, 8'h21, 8'h11, 8'h01};
        req_b     = {8'h03, 8'h02, 8'h01, 8'h00};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            nvec++;
            if (req_ready !== exp_gnt[c]) begin
                nerr++;
                $display("FAIL fair_grant c%0d: got %b want %b", c, req_ready, exp_gnt[c]);
            end
            nvec++;
            if ((req_ready & (req_ready - 1'b1)) !== '0) begin
                nerr++;
                $display("FAIL fair_onehot c%0d: got %b want one-hot", c, req_ready);
            end
            if (c >= 2 && c % 2 == 0) begin
                nvec++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'(c / 2 - 1) ||
                    rsp_sum !== exp_sum[c / 2 - 1]) begin
                    nerr++;
                    $display("FAIL fair_rsp c%0d: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h",
                             c, rsp_valid, rsp_id, rsp_sum, c / 2 - 1, exp_sum[c / 2 - 1]);
                end
            end
            next_cycle();
        end
        req_valid = '0;
        repeat (3) next_cycle();
    endtask

    task automatic test_single;
        req_a[2*WIDTH +: WIDTH] = 8'h12;
        req_b[2*WIDTH +: WIDTH] = 8'h34;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0100) begin
            nerr++;
            $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_exec: got rdy=%b vld=%b want 0000/0", req_ready, rsp_valid);
        end
        next_cycle();
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin
            nerr++;
            $display("FAIL single_rsp: got v=%b sum=%h c=%b id=%0d want 1/46/0/2",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        next_cycle();
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_done: got vld=%b want 0", rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_backpressure;
        req_a[0 +: WIDTH]     = 8'h55;
        req_b[0 +: WIDTH]     = 8'h22;
        req_a[WIDTH +: WIDTH] = 8'h80;
        req_b[WIDTH +: WIDTH] = 8'h80;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b0001) begin
            nerr++;
            $display("FAIL bp_grant: got %b want 0001", req_ready);
        end
        next_cycle();
        req_valid = 4'b0010;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nvec++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 8'h77 || rsp_carry !== 1'b0 ||
                rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
                nerr++;
                $display("FAIL bp_hold c%0d: got v=%b sum=%h c=%b id=%0d rdy=%b want 1/77/0/0/0000",
                         c, rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h77 || req_ready !== 4'b0010) begin
            nerr++;
            $display("FAIL bp_release: got v=%b sum=%h rdy=%b want 1/77/0010",
                     rsp_valid, rsp_sum, req_ready);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h00 || rsp_carry !== 1'b1 || rsp_id !== 2'd1) begin
            nerr++;
            $display("FAIL bp_next_rsp: got v=%b sum=%h c=%b id=%0d want 1/00/1/1",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_overflow_wrap;
        logic [CNTW-1:0] prev;
        logic [CNTW-1:0] diff;
        do_reset();
        req_a     = {4{8'hFF}};
        req_b     = {4{8'h01}};
        rsp_ready = 1'b1;
        prev      = '0;
        for (int c = 0; c < 35; c++) begin
            req_valid = (c <= 32) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c % 2 == 1) begin
                nvec++;
                if (issue_cnt_gray !== gray_tab[((c + 1) / 2) % 16]) begin
                    nerr++;
                    $display("FAIL wrap_gray c%0d: got %b want %b",
                             c, issue_cnt_gray, gray_tab[((c + 1) / 2) % 16]);
                end
                diff = issue_cnt_gray ^ prev;
                nvec++;
                if ($countones(diff) != 1) begin
                    nerr++;
                    $display("FAIL wrap_onebit c%0d: got %b->%b want one bit change",
                             c, prev, issue_cnt_gray);
                end
                prev = issue_cnt_gray;
            end else if (c >= 2) begin
                nvec++;
                if (rsp_valid !== 1'b1 || rsp_sum !== 8'h00 || rsp_carry !== 1'b1) begin
                    nerr++;
                    $display("FAIL ovf_rsp c%0d: got v=%b sum=%h c=%b want 1/00/1",
                             c, rsp_valid, rsp_sum, rsp_carry);
                end
            end
            next_cycle();
        end
        nvec++;
        if (issue_cnt_gray !== 4'b0001) begin
            nerr++;
            $display("FAIL wrap_final: got %b want 0001", issue_cnt_gray);
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req_a[WIDTH +: WIDTH]   = 8'h11;
        req_b[WIDTH +: WIDTH]   = 8'h22;
        req_a[3*WIDTH +: WIDTH] = 8'h0A;
        req_b[3*WIDTH +: WIDTH] = 8'h05;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        next_cycle();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset_outputs");
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nvec++;
            if (rsp_valid !== 1'b0) begin
                nerr++;
                $display("FAIL mid_no_rsp c%0d: got vld=%b want 0", c, rsp_valid);
            end
            next_cycle();
        end
        req_valid = 4'b1000;
        @(negedge clk);
        nvec++;
        if (req_ready !== 4'b1000) begin
            nerr++;
            $display("FAIL mid_new_grant: got %b want 1000", req_ready);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h0F || rsp_carry !== 1'b0 ||
            rsp_id !== 2'd3 || issue_cnt_gray !== 4'b0001) begin
            nerr++;
            $display("FAIL mid_new_rsp: got v=%b sum=%h c=%b id=%0d gray=%b want 1/0f/0/3/0001",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id, issue_cnt_gray);
        end
        next_cycle();
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_overflow_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares one registered WIDTH-bit adder (sum = a + b, one-cycle latency) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time with a one-hot grant, sequences the adder, and returns the sum tagged with the requester index over a valid/ready response port. It also exports a Gray-coded issue counter, so the existing reset, one-hot and Gray property checks can bind directly to its outputs.

## Interface
- WIDTH, 8: operand and sum width.
- NREQ, 4: number of requesters; legal range 2..16.
- IDW, $clog2(NREQ): width of the response ID.
- CNTW, 4: width of the Gray issue counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant; at most one bit is set in any cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_sum  out  WIDTH  (a + b) mod 2^WIDTH.
- rsp_carry  out  1  carry out of the addition.
- rsp_id  out  IDW  index of the granted requester.
- issue_cnt_gray  out  CNTW  Gray-coded count of accepted requests.

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE: if any req_valid is set, assert req_ready for the round-robin winner and no other bit. The request transfers in that cycle. Latch the operands and the winner index into the adder input registers, then go to EXEC. If no req_valid is set, stay in IDLE.
- EXEC: the adder register captures {carry, sum} = a + b at the end of this cycle. Then go to RESP. req_ready is 0 in this state.
- RESP: rsp_valid = 1. rsp_sum, rsp_carry and rsp_id stay stable until rsp_ready is seen.
  - rsp_ready = 1 and a req_valid is pending: grant the winner in this same cycle (req_ready asserted in RESP) and go to EXEC. This gives back-to-back throughput of one result per 2 cycles.
  - rsp_ready = 1 and no request pending: go to IDLE.
  - rsp_ready = 0: stay in RESP, req_ready = 0.
- Round-robin: the pointer holds the highest-priority index.
  - Search order is ptr, ptr+1, … wrapping mod NREQ.
  - After a grant to index g, the pointer becomes (g+1) mod NREQ.
  - The pointer does not change when nothing is granted.
- A requester that drops req_valid before it is granted loses nothing, because no state is recorded for it. Operands are sampled only in the grant cycle.
- Issue counter: a binary counter increments on every accepted request (any req_valid & req_ready) and wraps from 2^CNTW−1 to 0. issue_cnt_gray = bin ^ (bin >> 1), registered, so exactly one bit changes per increment, including at wrap.

## Timing
- Reset (asynchronous assertion, synchronous release) drives:
  - state = IDLE, rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_carry = 0, rsp_id = 0, issue_cnt_gray = 0.
- First grant can occur in the first cycle after rst_n deasserts.
- Grant to rsp_valid is 2 cycles: grant in cycle t, EXEC in t+1, rsp_valid high from t+2.
- req_ready depends combinationally on req_valid, state and pointer. It never depends combinationally on rsp_ready except in RESP.
- Reset mid-operation discards any in-flight operands and response with no output. The pointer returns to 0.
- Overflow: 0xFF + 0x01 at WIDTH=8 gives sum 0x00, carry 1.

## Structure
- Package adder_arbiter_pkg holds:
  - the state_e enum typedef {IDLE, EXEC, RESP}.
  - a bin2gray function.
- Sub-module rr_arbiter #(NREQ) takes inputs req, ptr and en. It outputs a one-hot gnt and the gnt_idx. It is purely combinational; the pointer register lives in the parent.
- The top holds the FSM, operand/adder registers, response registers and issue counter.

## Test plan
- Reset values: hold rst_n = 0 with random inputs. Every output must be 0. Then release and check state = IDLE.
- Single request: req_valid = 4'b0100, a = 0x12, b = 0x34 → req_ready = 4'b0100 for 1 cycle. Two cycles later rsp_valid = 1, sum = 0x46, carry = 0, id = 2.
- Fairness: req_valid = 4'b1111 held and rsp_ready = 1 → grant order is ids 0,1,2,3,0, one grant every 2 cycles. Check req_ready is one-hot at every cycle.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid → the response is held unchanged and req_ready stays 0 throughout. Raising rsp_ready then accepts the response.
- Overflow and counter wrap: with CNTW = 4, issue 17 requests of 0xFF + 0x01. Every response must show sum 0x00, carry 1. issue_cnt_gray must step through the 4-bit Gray sequence and wrap to 0000 after 16 requests, with one bit changing per step.
- Reset mid-flight: assert rst_n = 0 during EXEC → rsp_valid never rises for that request. After release, a new request with id 3 is granted and answered normally.
